// File: rtl/rand_range_sampler.sv
// -----------------------------------------------------------------------------
// rand_range_sampler
//
// Turns the raw 16-bit LFSR stream into a uniformly distributed value in
// [0, limit) by masked rejection sampling. A request latches the limit.
// The next cycle builds the smallest all-ones mask that covers limit-1.
// After that, each cycle tests one masked LFSR word against the limit.
// If MAX_TRIES words in a row are rejected, the last candidate is folded
// back into range (c - lim). This keeps the worst-case latency fixed.
//
// Optional build feature (macro RAND_RANGE_STATS_EN):
//   Adds rej_count_out / fb_count_out. These are saturating 16-bit counts
//   of rejected samples and of fallback results since reset.
// -----------------------------------------------------------------------------
module rand_range_sampler #(
    parameter int WIDTH     = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] lfsr_in,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             req_in,
    output logic [WIDTH-1:0] value_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             fallback_out,
`ifdef RAND_RANGE_STATS_EN
    output logic [15:0]      rej_count_out,
    output logic [15:0]      fb_count_out,
`endif
    output logic             err_out
);

    // Try counter must be able to hold MAX_TRIES-1 (largest value kept).
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MASK   = 2'b01,
        ST_SAMPLE = 2'b10
    } state_t;

    // Smear every set bit to the right. The result is the smallest
    // 2^k-1 value that is >= v.
    function automatic logic [WIDTH-1:0] smear_right(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    state_t           state_r,    state_next_s;
    logic [WIDTH-1:0] lim_r,      lim_next_s;
    logic [WIDTH-1:0] mask_r,     mask_next_s;
    logic [TRY_W-1:0] tries_r,    tries_next_s;
    logic [WIDTH-1:0] value_r,    value_next_s;
    logic             valid_r,    valid_next_s;
    logic             busy_r,     busy_next_s;
    logic             fallback_r, fallback_next_s;
    logic             err_r,      err_next_s;

    // Candidate for this cycle and its accept / last-chance decisions.
    logic [WIDTH-1:0] cand_s;
    logic             accept_s;
    logic             last_try_s;

    assign cand_s     = lfsr_in & mask_r;
    assign accept_s   = (cand_s < lim_r);
    assign last_try_s = ((int'(tries_r) + 1) >= MAX_TRIES);

    // Next-state and next-output logic. Every register holds its value
    // unless a case overrides it.
    always_comb begin
        state_next_s    = state_r;
        lim_next_s      = lim_r;
        mask_next_s     = mask_r;
        tries_next_s    = tries_r;
        value_next_s    = value_r;
        valid_next_s    = 1'b0;
        fallback_next_s = fallback_r;
        err_next_s      = err_r;

        case (state_r)
            ST_IDLE: begin
                if (req_in) begin
                    lim_next_s   = limit_in;
                    tries_next_s = {TRY_W{1'b0}};
                    if (limit_in == {WIDTH{1'b0}}) begin
                        // An empty range has no valid result.
                        // Report it at once and stay idle.
                        value_next_s    = {WIDTH{1'b0}};
                        err_next_s      = 1'b1;
                        fallback_next_s = 1'b0;
                        valid_next_s    = 1'b1;
                        state_next_s    = ST_IDLE;
                    end else begin
                        state_next_s = ST_MASK;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_MASK: begin
                // lim >= 1 here, so lim-1 cannot underflow.
                mask_next_s  = smear_right(lim_r - WIDTH'(1));
                state_next_s = ST_SAMPLE;
            end

            ST_SAMPLE: begin
                if (accept_s) begin
                    value_next_s    = cand_s;
                    fallback_next_s = 1'b0;
                    err_next_s      = 1'b0;
                    valid_next_s    = 1'b1;
                    state_next_s    = ST_IDLE;
                end else if (last_try_s) begin
                    // mask < 2*lim, so cand - lim is always below lim.
                    value_next_s    = cand_s - lim_r;
                    fallback_next_s = 1'b1;
                    err_next_s      = 1'b0;
                    valid_next_s    = 1'b1;
                    state_next_s    = ST_IDLE;
                end else begin
                    tries_next_s = tries_r + TRY_W'(1);
                    state_next_s = ST_SAMPLE;
                end
            end

            default: begin
                // Recover from an illegal encoding without producing a result.
                state_next_s = ST_IDLE;
            end
        endcase

        busy_next_s = (state_next_s == ST_MASK) || (state_next_s == ST_SAMPLE);
    end

    // State and registered outputs. Reset aborts any request in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            lim_r      <= {WIDTH{1'b0}};
            mask_r     <= {WIDTH{1'b0}};
            tries_r    <= {TRY_W{1'b0}};
            value_r    <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            fallback_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            lim_r      <= lim_next_s;
            mask_r     <= mask_next_s;
            tries_r    <= tries_next_s;
            value_r    <= value_next_s;
            valid_r    <= valid_next_s;
            busy_r     <= busy_next_s;
            fallback_r <= fallback_next_s;
            err_r      <= err_next_s;
        end
    end

    assign value_out    = value_r;
    assign valid_out    = valid_r;
    assign busy_out     = busy_r;
    assign fallback_out = fallback_r;
    assign err_out      = err_r;

`ifdef RAND_RANGE_STATS_EN
    logic [15:0] rej_cnt_r;
    logic [15:0] fb_cnt_r;
    logic        rej_evt_s;
    logic        fb_evt_s;

    // Every rejected candidate counts, including the one that triggers the fallback.
    assign rej_evt_s = (state_r == ST_SAMPLE) && !accept_s;
    assign fb_evt_s  = rej_evt_s && last_try_s;

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rej_cnt_r <= 16'h0000;
            fb_cnt_r  <= 16'h0000;
        end else begin
            if (rej_evt_s && (rej_cnt_r != 16'hFFFF)) begin
                rej_cnt_r <= rej_cnt_r + 16'h0001;
            end else begin
                rej_cnt_r <= rej_cnt_r;
            end
            if (fb_evt_s && (fb_cnt_r != 16'hFFFF)) begin
                fb_cnt_r <= fb_cnt_r + 16'h0001;
            end else begin
                fb_cnt_r <= fb_cnt_r;
            end
        end
    end

    assign rej_count_out = rej_cnt_r;
    assign fb_count_out  = fb_cnt_r;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
// -----------------------------------------------------------------------------
// Directed testbench for rand_range_sampler (WIDTH=16, MAX_TRIES=8).
// Inputs change 1 time unit after a rising edge.
// Outputs are read at the same point, after the preceding edge.
// -----------------------------------------------------------------------------
module tb_rand_range_sampler;

    logic        clk_in;
    logic        rst_in;
    logic [15:0] lfsr_in;
    logic [15:0] limit_in;
    logic        req_in;
    logic [15:0] value_out;
    logic        valid_out;
    logic        busy_out;
    logic        fallback_out;
    logic        err_out;
`ifdef RAND_RANGE_STATS_EN
    logic [15:0] rej_count_out;
    logic [15:0] fb_count_out;
`endif

    int n_vec;
    int n_err;

    rand_range_sampler #(.WIDTH(16), .MAX_TRIES(8)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .lfsr_in      (lfsr_in),
        .limit_in     (limit_in),
        .req_in       (req_in),
        .value_out    (value_out),
        .valid_out    (valid_out),
        .busy_out     (busy_out),
        .fallback_out (fallback_out),
`ifdef RAND_RANGE_STATS_EN
        .rej_count_out(rej_count_out),
        .fb_count_out (fb_count_out),
`endif
        .err_out      (err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; req_in = 1'b0; limit_in = 16'h0000; lfsr_in = 16'h0000;
        #2;
        rst_in = 1'b0;
        tick(); tick();
        n_vec++; if (value_out !== 16'h0000) begin n_err++; $display("FAIL reset_value: got %h want %h", value_out, 16'h0000); end
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_vec++; if (fallback_out !== 1'b0) begin n_err++; $display("FAIL reset_fallback: got %b want 0", fallback_out); end
        n_vec++; if (err_out !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_out); end
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_fallback();
        // limit 5 -> mask 7; word 6 is always rejected.
        limit_in = 16'd5; lfsr_in = 16'h0006; req_in = 1'b1;
        tick();                                   // edge 0
        req_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin        // edges 1..8
            tick();
            n_vec++; if (valid_out !== 1'b0 || busy_out !== 1'b1) begin n_err++; $display("FAIL fb_wait_e%0d: valid=%b busy=%b want valid=0 busy=1", i, valid_out, busy_out); end
        end
        tick();                                   // edge 9: eighth rejection
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL fb_valid: got %b want 1", valid_out); end
        n_vec++; if (value_out !== 16'h0001) begin n_err++; $display("FAIL fb_value: got %h want %h", value_out, 16'h0001); end
        n_vec++; if (fallback_out !== 1'b1) begin n_err++; $display("FAIL fb_flag: got %b want 1", fallback_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL fb_busy: got %b want 0", busy_out); end
`ifdef RAND_RANGE_STATS_EN
        n_vec++; if (rej_count_out !== 16'd8) begin n_err++; $display("FAIL fb_rejcnt: got %0d want 8", rej_count_out); end
        n_vec++; if (fb_count_out !== 16'd1) begin n_err++; $display("FAIL fb_fbcnt: got %0d want 1", fb_count_out); end
`endif
        tick();
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL fb_pulse: got %b want 0", valid_out); end
        n_vec++; if (value_out !== 16'h0001 || fallback_out !== 1'b1) begin n_err++; $display("FAIL fb_hold: value=%h fb=%b want 0001/1", value_out, fallback_out); end
    endtask

    task automatic test_normal_accept();
        limit_in = 16'd10; lfsr_in = 16'h000C; req_in = 1'b1;
        tick();                                   // edge 0
        req_in = 1'b0; limit_in = 16'd2;          // later limit changes must not matter
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL acc_busy: got %b want 1", busy_out); end
        tick();                                   // edge 1 (mask)
        tick();                                   // edge 2: 0xC rejected
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL acc_rej: got %b want 0", valid_out); end
        lfsr_in = 16'h0007;
        tick();                                   // edge 3: 7 accepted
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL acc_valid: got %b want 1", valid_out); end
        n_vec++; if (value_out !== 16'h0007) begin n_err++; $display("FAIL acc_value: got %h want %h", value_out, 16'h0007); end
        n_vec++; if (fallback_out !== 1'b0) begin n_err++; $display("FAIL acc_fbflag: got %b want 0", fallback_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL acc_idle: got %b want 0", busy_out); end
        tick();
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL acc_pulse: got %b want 0", valid_out); end
    endtask

    task automatic test_bounds();
        // limit 1: mask 0, result 0 at the earliest point.
        limit_in = 16'd1; lfsr_in = 16'hBEEF; req_in = 1'b1;
        tick(); req_in = 1'b0;
        tick();
        tick();
        n_vec++; if (valid_out !== 1'b1 || value_out !== 16'h0000) begin n_err++; $display("FAIL lim1: valid=%b value=%h want 1/0000", valid_out, value_out); end
        // limit 0x8000: mask 0x7FFF.
        limit_in = 16'h8000; lfsr_in = 16'hFFFF; req_in = 1'b1;
        tick(); req_in = 1'b0;
        tick();
        tick();
        n_vec++; if (valid_out !== 1'b1 || value_out !== 16'h7FFF) begin n_err++; $display("FAIL lim8000: valid=%b value=%h want 1/7fff", valid_out, value_out); end
        // limit 0: immediate error result, never busy.
        limit_in = 16'h0000; req_in = 1'b1;
        tick(); req_in = 1'b0;
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL lim0_valid: got %b want 1", valid_out); end
        n_vec++; if (value_out !== 16'h0000) begin n_err++; $display("FAIL lim0_value: got %h want 0000", value_out); end
        n_vec++; if (err_out !== 1'b1) begin n_err++; $display("FAIL lim0_err: got %b want 1", err_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL lim0_busy: got %b want 0", busy_out); end
        tick();
        n_vec++; if (busy_out !== 1'b0 || valid_out !== 1'b0 || err_out !== 1'b1) begin n_err++; $display("FAIL lim0_after: busy=%b valid=%b err=%b want 0/0/1", busy_out, valid_out, err_out); end
        // limit 0xFFFF: all-ones mask, 0xFFFF rejected, 0x1234 accepted.
        limit_in = 16'hFFFF; lfsr_in = 16'hFFFF; req_in = 1'b1;
        tick(); req_in = 1'b0;
        tick();
        tick();
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL limffff_rej: got %b want 0", valid_out); end
        lfsr_in = 16'h1234;
        tick();
        n_vec++; if (valid_out !== 1'b1 || value_out !== 16'h1234 || err_out !== 1'b0) begin n_err++; $display("FAIL limffff: valid=%b value=%h err=%b want 1/1234/0", valid_out, value_out, err_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        limit_in = 16'd10; lfsr_in = 16'h0000; req_in = 1'b1;
        tick(); req_in = 1'b0;                    // edge 0
        tick();                                   // edge 1
        lfsr_in = 16'h000F; req_in = 1'b1; limit_in = 16'd3;
        tick();                                   // edge 2: reject, request ignored
        n_vec++; if (valid_out !== 1'b0 || busy_out !== 1'b1) begin n_err++; $display("FAIL busy_req: valid=%b busy=%b want 0/1", valid_out, busy_out); end
        req_in = 1'b0; lfsr_in = 16'h0004;
        tick();                                   // edge 3: 4 under limit 10
        n_vec++; if (valid_out !== 1'b1 || value_out !== 16'h0004) begin n_err++; $display("FAIL busy_first: valid=%b value=%h want 1/0004", valid_out, value_out); end
        req_in = 1'b1; limit_in = 16'd3;
        tick();                                   // edge 4: accepted while valid high
        req_in = 1'b0; limit_in = 16'hFFFF;
        n_vec++; if (busy_out !== 1'b1 || valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_accept: busy=%b valid=%b want 1/0", busy_out, valid_out); end
        tick();                                   // edge 5: mask 3
        lfsr_in = 16'h0006;
        tick();                                   // edge 6: 6&3=2 < 3
        n_vec++; if (valid_out !== 1'b1 || value_out !== 16'h0002 || fallback_out !== 1'b0) begin n_err++; $display("FAIL b2b_value: valid=%b value=%h fb=%b want 1/0002/0", valid_out, value_out, fallback_out); end
        tick();
    endtask

    task automatic test_reset_midop();
        limit_in = 16'd10; lfsr_in = 16'h000F; req_in = 1'b1;
        tick(); req_in = 1'b0;
        tick();
        tick();                                   // edge 2: rejected, in sample phase
        rst_in = 1'b0;
        lfsr_in = 16'h0003;
        #1;
        n_vec++; if (value_out !== 16'h0000 || busy_out !== 1'b0 || valid_out !== 1'b0 || fallback_out !== 1'b0 || err_out !== 1'b0) begin n_err++; $display("FAIL rst_mid: value=%h busy=%b valid=%b fb=%b err=%b want all zero", value_out, busy_out, valid_out, fallback_out, err_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (valid_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL rst_hold%0d: valid=%b busy=%b want 0/0", i, valid_out, busy_out); end
        end
        rst_in = 1'b1;
        tick();
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_novalid: got %b want 0", valid_out); end
        limit_in = 16'd10; lfsr_in = 16'h0002; req_in = 1'b1;
        tick(); req_in = 1'b0;
        tick();
        tick();
        n_vec++; if (valid_out !== 1'b1 || value_out !== 16'h0002) begin n_err++; $display("FAIL rst_fresh: valid=%b value=%h want 1/0002", valid_out, value_out); end
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fallback();
        test_normal_accept();
        test_bounds();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
